// File: rtl/mem_req_ctrl_pkg.sv
// Shared CPU definitions for the data-memory request path:
// controller state encoding and the default bus timeout.
package mem_req_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned MEM_CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-memory request controller: turns a pipeline access into a single
// bus transaction, stalls the pipeline while it is outstanding, and times it out.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] paddr,
  input  logic        uncached,
  input  logic        mmu_exp,
  input  logic        flush,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_bus_err,
  output logic [31:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [MEM_CNT_W-1:0] CNT_LAST = MEM_CNT_W'(TIMEOUT - 1);

  mem_state_e           state;
  logic [MEM_CNT_W-1:0] cnt;
  logic                 flushed;
  logic                 done_ok;
  logic                 timed_out;
  logic                 start;
  logic                 cancel;

  assign start  = (state == ST_IDLE) & mem_en & ~mmu_exp & ~flush;
  assign cancel = flushed | flush;

  // Completion pulses are gated by flush in the DONE cycle itself, so the
  // registered completion flags are qualified combinationally here.
  always_comb begin
    mem_stall   = start | (state == ST_REQ);
    mem_done    = (state == ST_DONE) & done_ok & ~flush;
    mem_bus_err = (state == ST_DONE) & done_ok & timed_out & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      flushed      <= 1'b0;
      done_ok      <= 1'b0;
      timed_out    <= 1'b0;
      mem_rdata    <= '0;
      bus_addr     <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      bus_uncached <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_addr     <= paddr;
            bus_be       <= mem_be;
            bus_wdata    <= mem_wdata;
            bus_uncached <= uncached;
            bus_read     <= ~mem_we;
            bus_write    <= mem_we;
            cnt          <= '0;
            flushed      <= 1'b0;
            done_ok      <= 1'b0;
            timed_out    <= 1'b0;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) flushed <= 1'b1;
          // Ack takes priority over a coinciding timeout.
          if (bus_ack) begin
            if (bus_read && !cancel) mem_rdata <= bus_rdata;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            done_ok   <= ~cancel;
            timed_out <= 1'b0;
            state     <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            done_ok   <= ~cancel;
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_mem_req_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_we, uncached, mmu_exp, flush, bus_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, paddr, bus_rdata;
  logic        mem_stall, mem_done, mem_bus_err;
  logic [31:0] mem_rdata, bus_addr, bus_wdata;
  logic        bus_read, bus_write, bus_uncached;
  logic [3:0]  bus_be;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_rdata;

  mem_req_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .paddr(paddr),
    .uncached(uncached), .mmu_exp(mmu_exp), .flush(flush),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_bus_err(mem_bus_err), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_uncached(bus_uncached), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: ack arrives in REQ cycle d (d > T means never), flush is
  // raised in cycle fl (1..n = REQ cycles, n+1 = DONE cycle, 0 = none).
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic unc, input int unsigned d,
                     input int unsigned fl, input logic [31:0] ack_data);
    int unsigned n;
    bit          tmo;
    bit          flush_req;
    bit          exp_done;
    n         = (d <= T) ? d : T;
    tmo       = (d > T);
    flush_req = (fl >= 1) && (fl <= n);
    exp_done  = (fl == 0);

    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = we; mem_be = be; paddr = addr; mem_wdata = wdata;
    uncached = unc; mmu_exp = 1'b0; flush = 1'b0;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    @(negedge clk);
    check("start_stall", 32'(mem_stall), 32'd1);
    check("start_read", 32'(bus_read), 32'd0);
    check("start_write", 32'(bus_write), 32'd0);

    for (int unsigned k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      paddr = $urandom; mem_wdata = $urandom; mem_be = 4'($urandom);
      uncached = 1'($urandom); mem_we = 1'($urandom);
      bus_ack = (k == d);
      bus_rdata = (k == d) ? ack_data : $urandom;
      flush = (k == fl);
      @(negedge clk);
      check("req_read", 32'(bus_read), 32'(!we));
      check("req_write", 32'(bus_write), 32'(we));
      check("req_addr", bus_addr, addr);
      check("req_be", 32'(bus_be), 32'(be));
      check("req_wdata", bus_wdata, wdata);
      check("req_unc", 32'(bus_uncached), 32'(unc));
      check("req_stall", 32'(mem_stall), 32'd1);
      check("req_done", 32'(mem_done), 32'd0);
      check("req_rdata", mem_rdata, exp_rdata);
    end

    @(posedge clk); #1;
    bus_ack = 1'($urandom); bus_rdata = $urandom; flush = (fl == n + 1);
    if (!we && !tmo && !flush_req) exp_rdata = ack_data;
    @(negedge clk);
    check("done_pulse", 32'(mem_done), 32'(exp_done));
    check("done_err", 32'(mem_bus_err), 32'(exp_done && tmo));
    check("done_stall", 32'(mem_stall), 32'd0);
    check("done_read", 32'(bus_read), 32'd0);
    check("done_write", 32'(bus_write), 32'd0);
    check("done_rdata", mem_rdata, exp_rdata);

    @(posedge clk); #1;
    mem_en = 1'b0; flush = 1'b0; bus_ack = 1'($urandom);
    @(negedge clk);
    check("idle_stall", 32'(mem_stall), 32'd0);
    check("idle_done", 32'(mem_done), 32'd0);
    check("idle_err", 32'(mem_bus_err), 32'd0);
    check("idle_read", 32'(bus_read), 32'd0);
    check("idle_rdata", mem_rdata, exp_rdata);
  endtask

  // Access refused by the MMU or killed by flush before issue.
  task automatic refused(input logic by_mmu);
    for (int unsigned c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      mem_en = 1'b1; mem_we = 1'($urandom); paddr = $urandom; mem_wdata = $urandom;
      mem_be = 4'($urandom); mmu_exp = by_mmu; flush = by_mmu ? 1'($urandom) : 1'b1;
      bus_ack = 1'($urandom); bus_rdata = $urandom;
      @(negedge clk);
      check("exc_stall", 32'(mem_stall), 32'd0);
      check("exc_read", 32'(bus_read), 32'd0);
      check("exc_write", 32'(bus_write), 32'd0);
      check("exc_done", 32'(mem_done), 32'd0);
    end
    @(posedge clk); #1;
    mem_en = 1'b0; mmu_exp = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    check("exc_after_done", 32'(mem_done), 32'd0);
    check("exc_rdata", mem_rdata, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_be = '0; mem_wdata = '0;
    paddr = '0; uncached = 1'b0; mmu_exp = 1'b0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0; exp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_read", 32'(bus_read), 32'd0);
    check("rst_write", 32'(bus_write), 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_err", 32'(mem_bus_err), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_unc", 32'(bus_uncached), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    rst_n = 1'b1;

    txn(1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 3, 0, 32'hDEAD_BEEF);
    refused(1'b1);
    refused(1'b0);
    txn(1'b0, 4'hF, 32'h0000_2000, 32'h0, 1'b0, T + 1, 0, 32'h0);
    txn(1'b0, 4'hF, 32'h0000_3000, 32'h0, 1'b0, T, 0, 32'hCAFE_0001);
    txn(1'b0, 4'hF, 32'h0000_4000, 32'h0, 1'b0, 3, 2, 32'h5555_AAAA);
    txn(1'b1, 4'b0011, 32'h0000_5000, 32'h1234_5678, 1'b1, 2, 0, 32'h0);
    txn(1'b0, 4'hF, 32'h0000_6000, 32'h0, 1'b0, 1, 2, 32'h0BAD_F00D);
    txn(1'b0, 4'hF, 32'h0000_7000, 32'h0, 1'b0, T + 2, 2, 32'h0);
    txn(1'b0, 4'hF, 32'h0000_8000, 32'h0, 1'b0, 1, 0, 32'h1111_2222);

    // Reset while a load is on the bus.
    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = 1'b0; paddr = 32'h0000_9000; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_read_before_rst", 32'(bus_read), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_en = 1'b0;
    #1;
    check("mid_rst_read", 32'(bus_read), 32'd0);
    check("mid_rst_stall", 32'(mem_stall), 32'd0);
    check("mid_rst_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; exp_rdata = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'($urandom); bus_rdata = $urandom;
      @(negedge clk);
      check("post_rst_done", 32'(mem_done), 32'd0);
      check("post_rst_stall", 32'(mem_stall), 32'd0);
      check("post_rst_read", 32'(bus_read), 32'd0);
      check("post_rst_rdata", mem_rdata, exp_rdata);
    end

    for (int unsigned i = 0; i < 40; i++) begin
      int unsigned kind, d, n, fl;
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        refused(1'($urandom));
      end else begin
        d  = $urandom_range(1, T + 2);
        n  = (d <= T) ? d : T;
        fl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
        txn(1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom), d, fl, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
